bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Two-master arbiter for the native picorv32-style memory bus (valid/ready, addr, wstrb, wdata, rdata). Sits between the CPU (master 0) and an auxiliary bus master (master 1: test pattern generator, DMA) on one side, and the shared peripheral bus (`busInterface` decode, memory, gpio, uartTx, prng, timer) on the other. It grants one master at a time with round-robin fairness, holds the grant until the slave completes the transfer, and terminates hung transfers with a watchdog.

## Interface
- `TIMEOUT`, 1023: cycles a granted transfer may wait for slave ready; 0 disables the watchdog.
- `ERR_DATA`, 32'hDEADBEEF: rdata returned on a watchdog-terminated transfer.
- `clk`  in  1  system clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `m0_mem_valid`, `m1_mem_valid`  in  1  master requests.
- `m0_mem_instr`, `m1_mem_instr`  in  1  instruction-fetch flag.
- `m0_mem_addr`, `m1_mem_addr`  in  32  address.
- `m0_mem_wstrb`, `m1_mem_wstrb`  in  4  byte write strobes; 0 means read.
- `m0_mem_wdata`, `m1_mem_wdata`  in  32  write data.
- `m0_mem_ready`, `m1_mem_ready`  out  1  transfer complete.
- `m0_mem_rdata`, `m1_mem_rdata`  out  32  read data.
- `s_mem_valid`, `s_mem_instr`  out  1  to slave bus.
- `s_mem_addr`, `s_mem_wdata`  out  32  to slave bus.
- `s_mem_wstrb`  out  4  to slave bus.
- `s_mem_ready`  in  1  from `busInterface`.
- `s_mem_rdata`  in  32  from `busInterface`.
- `grant`  out  2  one-hot current owner; 00 when idle.
- `timeout_err`  out  1  one-cycle pulse on watchdog termination.

## Operation
- States: IDLE, GNT0, GNT1. Registers: state, `last` (last master served), watchdog counter.
- IDLE: one valid → GNTn for that master. Both valid → grant the master not equal to `last`. No valid → stay.
- GNTn: `s_mem_*` = master n fields, `s_mem_valid` = `mn_mem_valid`. `mn_mem_ready` = `s_mem_ready`, `mn_mem_rdata` = `s_mem_rdata` (combinational pass-through). On `s_mem_ready` → IDLE, `last` ← n.
- The other master, and both masters in IDLE: ready 0, rdata 0. Slave outputs in IDLE: all 0.
- Granted master drops valid before ready (protocol violation): return to IDLE next cycle; `last` unchanged; no ready issued.
- Watchdog: counter cleared on entering GNTn, increments each GNTn cycle without `s_mem_ready`. When it reaches `TIMEOUT` (TIMEOUT≠0): `s_mem_valid` forced 0, `mn_mem_ready` forced 1, `mn_mem_rdata` = `ERR_DATA`, `timeout_err` = 1 for that cycle; → IDLE, `last` ← n. `s_mem_ready` arriving in the same cycle wins: normal completion, no error.
- Counter width `$clog2(TIMEOUT+1)`, saturating; no wrap.

## Timing
- Reset (asynchronous assert, registers released on clk): state IDLE, `last` = 1 (master 0 wins the first contention), counter 0, `grant` 00, `timeout_err` 0, all ready/rdata/`s_mem_*` outputs 0.
- Arbitration latency: request seen in IDLE at cycle N → `s_mem_valid` high at N+1.
- Completion: `s_mem_ready` at cycle M → master ready at M, state IDLE at M+1, next grant at M+2 earliest. One bus-idle cycle between transfers.
- Reset mid-transfer: outputs drop to reset values immediately, without waiting for clk; the in-flight transfer is abandoned.

## Structure
- Shared package `xoro_bus_pkg`: state enum (IDLE, GNT0, GNT1) and the `ERR_DATA` default constant, reused by other bus masters and slaves.
- One sub-module, `bus_watchdog`: loadable saturating counter with clear and expiry output, parameterised by `TIMEOUT`. The mux and FSM stay in `bus_arbiter`.

## Test plan
- Reset, then m0 reads 0xFFFF0060 and slave ready 3 cycles after `s_mem_valid` → `grant` = 01 one cycle after request; m0 ready with rdata 0x0000000A when slave returns 0x0A; m1 ready stays 0.
- m0 and m1 request in the same cycle after reset → m0 served first. m1 is served next, with exactly one idle cycle between. Third contention goes to m0.
- m1 writes wdata 0x48 with wstrb 0001 to 0xFFFF0040 while m0 idle → `s_mem_addr`, `s_mem_wdata` and `s_mem_wstrb` match m1's values; m0 sees ready 0 and rdata 0.
- TIMEOUT=8, slave never ready → in the 8th GNT cycle m0 gets ready=1, rdata 0xDEADBEEF and a `timeout_err` pulse, and `s_mem_valid` goes 0. Repeat with `s_mem_ready` in that same cycle → normal rdata, no `timeout_err`.
- Assert `resetn` low mid-transfer with no clock edge → all outputs 0 immediately. After release, the first contention goes to m0.
- m0 drops valid during GNT0 → IDLE next cycle, no ready pulse; a pending m1 request is granted next.

Source files
------------

// File: rtl/xoro_bus_pkg.sv
// ---------------------------------------------------------------------------
// xoro_bus_pkg
// Shared definitions for masters and slaves on the native valid/ready memory
// bus: the arbiter state encoding and the read data that a master receives
// when a transfer is killed by the bus watchdog.
// No ports (package).
// ---------------------------------------------------------------------------
package xoro_bus_pkg;

   // Arbiter ownership states: nobody, master 0, master 1
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } arb_state_e;

   // Recognisable garbage returned on a watchdog-terminated read
   localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

endpackage

// File: rtl/bus_watchdog.sv
// ---------------------------------------------------------------------------
// bus_watchdog
// Saturating wait-cycle counter for a granted bus transfer. It counts the
// cycles a transfer has waited for the slave and flags expiry in the cycle
// whose increment would make the count reach TIMEOUT. TIMEOUT = 0 disables
// expiry entirely.
// Ports:
//   clk       in   system clock
//   resetn    in   asynchronous active-low reset
//   clear_i   in   load the counter with zero (no transfer in progress)
//   count_i   in   a granted transfer waited this cycle without ready
//   expire_o  out  this waiting cycle is the TIMEOUT-th one
// ---------------------------------------------------------------------------
module bus_watchdog #(
   parameter int TIMEOUT = 1023
) (
   input  logic clk,
   input  logic resetn,
   input  logic clear_i,
   input  logic count_i,
   output logic expire_o
);

   localparam bit ENABLED = (TIMEOUT != 0);
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
   localparam logic [CNT_W:0] LIMIT = (CNT_W + 1)'(TIMEOUT);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic [CNT_W:0]   countInc;

   // One extra bit so the comparison against TIMEOUT can never wrap
   assign countInc = {1'b0, count_q} + (CNT_W + 1)'(1);

   // Expiry is judged on the value the counter is about to take, so the
   // TIMEOUT-th waiting cycle is the one that terminates the transfer
   assign expire_o = ENABLED && count_i && (countInc >= LIMIT);

   // Next count: clear wins, otherwise count up and stick at the maximum
   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (count_i && (count_q != CNT_MAX)) begin
         count_d = countInc[CNT_W-1:0];
      end
   end

   // Counter register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
// Two-master round-robin arbiter for the native valid/ready memory bus.
// Master 0 is the CPU, master 1 an auxiliary master (pattern generator, DMA).
// A grant is held until the slave answers with ready, the master abandons
// the request, or the watchdog kills a hung transfer.
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   mN_mem_valid/instr/addr/
//     wstrb/wdata               request from master N (N = 0, 1)
//   mN_mem_ready/rdata          response to master N
//   s_mem_valid/instr/addr/
//     wstrb/wdata               request to the shared slave bus
//   s_mem_ready/rdata           response from the shared slave bus
//   grant                       one-hot owner, 00 when idle
//   timeout_err                 one-cycle pulse when the watchdog fires
// ---------------------------------------------------------------------------
module bus_arbiter
   import xoro_bus_pkg::*;
#(
   parameter int          TIMEOUT  = 1023,
   parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        m0_mem_valid,
   input  logic        m0_mem_instr,
   input  logic [31:0] m0_mem_addr,
   input  logic [3:0]  m0_mem_wstrb,
   input  logic [31:0] m0_mem_wdata,
   output logic        m0_mem_ready,
   output logic [31:0] m0_mem_rdata,
   input  logic        m1_mem_valid,
   input  logic        m1_mem_instr,
   input  logic [31:0] m1_mem_addr,
   input  logic [3:0]  m1_mem_wstrb,
   input  logic [31:0] m1_mem_wdata,
   output logic        m1_mem_ready,
   output logic [31:0] m1_mem_rdata,
   output logic        s_mem_valid,
   output logic        s_mem_instr,
   output logic [31:0] s_mem_addr,
   output logic [3:0]  s_mem_wstrb,
   output logic [31:0] s_mem_wdata,
   input  logic        s_mem_ready,
   input  logic [31:0] s_mem_rdata,
   output logic [1:0]  grant,
   output logic        timeout_err
);

   arb_state_e  state_q;
   arb_state_e  state_d;
   logic        last_q;
   logic        last_d;

   logic        granted;
   logic        selM1;
   logic        selValid;
   logic        selInstr;
   logic [31:0] selAddr;
   logic [3:0]  selWstrb;
   logic [31:0] selWdata;
   logic        respReady;
   logic [31:0] respRdata;
   logic        wdCount;
   logic        wdExpire;

   // Pick the request fields of whichever master currently owns the bus
   always_comb begin
      granted  = (state_q == GNT0) || (state_q == GNT1);
      selM1    = (state_q == GNT1);
      selValid = selM1 ? m1_mem_valid : m0_mem_valid;
      selInstr = selM1 ? m1_mem_instr : m0_mem_instr;
      selAddr  = selM1 ? m1_mem_addr  : m0_mem_addr;
      selWstrb = selM1 ? m1_mem_wstrb : m0_mem_wstrb;
      selWdata = selM1 ? m1_mem_wdata : m0_mem_wdata;
      wdCount  = granted && selValid && !s_mem_ready;
   end

   // Counter sits at zero whenever the bus is idle, so each grant starts fresh
   bus_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk      (clk),
      .resetn   (resetn),
      .clear_i  (!granted),
      .count_i  (wdCount),
      .expire_o (wdExpire)
   );

   // Arbitration and output muxing. A master that drops valid while granted
   // is simply released without a ready; a slave ready in the expiry cycle
   // takes priority because wdCount is already gated by s_mem_ready.
   always_comb begin
      state_d      = state_q;
      last_d       = last_q;
      grant        = 2'b00;
      timeout_err  = 1'b0;
      s_mem_valid  = 1'b0;
      s_mem_instr  = 1'b0;
      s_mem_addr   = '0;
      s_mem_wstrb  = '0;
      s_mem_wdata  = '0;
      respReady    = 1'b0;
      respRdata    = '0;
      m0_mem_ready = 1'b0;
      m0_mem_rdata = '0;
      m1_mem_ready = 1'b0;
      m1_mem_rdata = '0;

      case (state_q)
         IDLE: begin
            if (m0_mem_valid && m1_mem_valid) begin
               state_d = last_q ? GNT0 : GNT1;
            end else if (m0_mem_valid) begin
               state_d = GNT0;
            end else if (m1_mem_valid) begin
               state_d = GNT1;
            end
         end
         GNT0, GNT1: begin
            grant       = selM1 ? 2'b10 : 2'b01;
            s_mem_valid = selValid && !wdExpire;
            s_mem_instr = selInstr;
            s_mem_addr  = selAddr;
            s_mem_wstrb = selWstrb;
            s_mem_wdata = selWdata;
            if (!selValid) begin
               state_d = IDLE;
            end else begin
               respReady   = s_mem_ready || wdExpire;
               respRdata   = wdExpire ? ERR_DATA : s_mem_rdata;
               timeout_err = wdExpire;
               if (respReady) begin
                  state_d = IDLE;
                  last_d  = selM1;
               end
            end
            if (selM1) begin
               m1_mem_ready = respReady;
               m1_mem_rdata = respRdata;
            end else begin
               m0_mem_ready = respReady;
               m0_mem_rdata = respRdata;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and round-robin history; last = 1 lets master 0 win first contention
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
      end
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter
// Directed bench for bus_arbiter with a short watchdog (TIMEOUT = 8).
// Expected responses are queued when a slave answer is driven and compared
// by a monitor whenever a master sees ready.
// ---------------------------------------------------------------------------
module tb_bus_arbiter;

   localparam int TB_TIMEOUT = 8;

   logic        clk;
   logic        resetn;
   logic        m0_mem_valid;
   logic        m0_mem_instr;
   logic [31:0] m0_mem_addr;
   logic [3:0]  m0_mem_wstrb;
   logic [31:0] m0_mem_wdata;
   logic        m0_mem_ready;
   logic [31:0] m0_mem_rdata;
   logic        m1_mem_valid;
   logic        m1_mem_instr;
   logic [31:0] m1_mem_addr;
   logic [3:0]  m1_mem_wstrb;
   logic [31:0] m1_mem_wdata;
   logic        m1_mem_ready;
   logic [31:0] m1_mem_rdata;
   logic        s_mem_valid;
   logic        s_mem_instr;
   logic [31:0] s_mem_addr;
   logic [3:0]  s_mem_wstrb;
   logic [31:0] s_mem_wdata;
   logic        s_mem_ready;
   logic [31:0] s_mem_rdata;
   logic [1:0]  grant;
   logic        timeout_err;

   typedef struct {
      int          master;
      logic [31:0] rdata;
      logic        err;
   } sbEntry_t;

   sbEntry_t sbQueue[$];
   int checks = 0;
   int failures = 0;

   bus_arbiter #(
      .TIMEOUT  (TB_TIMEOUT),
      .ERR_DATA (32'hDEADBEEF)
   ) dut (
      .clk          (clk),
      .resetn       (resetn),
      .m0_mem_valid (m0_mem_valid),
      .m0_mem_instr (m0_mem_instr),
      .m0_mem_addr  (m0_mem_addr),
      .m0_mem_wstrb (m0_mem_wstrb),
      .m0_mem_wdata (m0_mem_wdata),
      .m0_mem_ready (m0_mem_ready),
      .m0_mem_rdata (m0_mem_rdata),
      .m1_mem_valid (m1_mem_valid),
      .m1_mem_instr (m1_mem_instr),
      .m1_mem_addr  (m1_mem_addr),
      .m1_mem_wstrb (m1_mem_wstrb),
      .m1_mem_wdata (m1_mem_wdata),
      .m1_mem_ready (m1_mem_ready),
      .m1_mem_rdata (m1_mem_rdata),
      .s_mem_valid  (s_mem_valid),
      .s_mem_instr  (s_mem_instr),
      .s_mem_addr   (s_mem_addr),
      .s_mem_wstrb  (s_mem_wstrb),
      .s_mem_wdata  (s_mem_wdata),
      .s_mem_ready  (s_mem_ready),
      .s_mem_rdata  (s_mem_rdata),
      .grant        (grant),
      .timeout_err  (timeout_err)
   );

   // Free-running clock, period 10
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Safety net so a broken design can never hang the run
   initial begin
      #100000;
      $display("[TB] FAIL sim_time_limit observed=running expected=finished");
      $fatal(1, "[TB] time limit");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input int m, input logic valid, input logic [31:0] addr,
                                input logic [3:0] wstrb, input logic [31:0] wdata);
      if (m == 0) begin
         m0_mem_valid = valid;
         m0_mem_instr = 1'b0;
         m0_mem_addr  = addr;
         m0_mem_wstrb = wstrb;
         m0_mem_wdata = wdata;
      end else begin
         m1_mem_valid = valid;
         m1_mem_instr = 1'b0;
         m1_mem_addr  = addr;
         m1_mem_wstrb = wstrb;
         m1_mem_wdata = wdata;
      end
   endtask

   task automatic slaveRespond(input logic ready, input logic [31:0] rdata);
      s_mem_ready = ready;
      s_mem_rdata = rdata;
   endtask

   task automatic expectResponse(input int m, input logic [31:0] rdata, input logic err);
      sbEntry_t e;
      e.master = m;
      e.rdata  = rdata;
      e.err    = err;
      sbQueue.push_back(e);
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic sampleCycle();
      @(negedge clk);
   endtask

   task automatic doReset();
      resetn = 1'b0;
      nextCycle();
      nextCycle();
      resetn = 1'b1;
   endtask

   // Scoreboard monitor: every master ready must match the oldest expectation
   always @(negedge clk) begin
      if (resetn === 1'b1 && (m0_mem_ready === 1'b1 || m1_mem_ready === 1'b1)) begin
         if (sbQueue.size() == 0) begin
            checkOutput("sb_unexpected_ready", {30'b0, m1_mem_ready, m0_mem_ready}, 32'd0);
         end else begin
            sbEntry_t e;
            e = sbQueue.pop_front();
            checkOutput("sb_ready_sel", {30'b0, m1_mem_ready, m0_mem_ready},
                        (e.master == 1) ? 32'd2 : 32'd1);
            checkOutput("sb_rdata", m1_mem_ready ? m1_mem_rdata : m0_mem_rdata, e.rdata);
            checkOutput("sb_timeout_err", {31'b0, timeout_err}, {31'b0, e.err});
         end
      end
   end

   initial begin
      resetn = 1'b0;
      applyStimulus(0, 1'b0, 32'h0, 4'h0, 32'h0);
      applyStimulus(1, 1'b0, 32'h0, 4'h0, 32'h0);
      slaveRespond(1'b0, 32'h0);

      // Reset values
      nextCycle();
      nextCycle();
      sampleCycle();
      checkOutput("rst_grant", {30'b0, grant}, 32'd0);
      checkOutput("rst_timeout_err", {31'b0, timeout_err}, 32'd0);
      checkOutput("rst_s_valid", {31'b0, s_mem_valid}, 32'd0);
      checkOutput("rst_s_addr", s_mem_addr, 32'd0);
      checkOutput("rst_m0_ready", {31'b0, m0_mem_ready}, 32'd0);
      checkOutput("rst_m0_rdata", m0_mem_rdata, 32'd0);
      checkOutput("rst_m1_ready", {31'b0, m1_mem_ready}, 32'd0);

      // m0 read, slave answers three cycles after s_mem_valid
      nextCycle();
      resetn = 1'b1;
      applyStimulus(0, 1'b1, 32'hFFFF0060, 4'h0, 32'h0);
      sampleCycle();
      checkOutput("t1_grant_req_cycle", {30'b0, grant}, 32'd0);
      nextCycle();
      sampleCycle();
      checkOutput("t1_grant", {30'b0, grant}, 32'd1);
      checkOutput("t1_s_valid", {31'b0, s_mem_valid}, 32'd1);
      checkOutput("t1_s_addr", s_mem_addr, 32'hFFFF0060);
      checkOutput("t1_s_wstrb", {28'b0, s_mem_wstrb}, 32'd0);
      for (int i = 0; i < 2; i++) begin
         nextCycle();
         sampleCycle();
         checkOutput("t1_wait_m0_ready", {31'b0, m0_mem_ready}, 32'd0);
      end
      nextCycle();
      expectResponse(0, 32'h0000000A, 1'b0);
      slaveRespond(1'b1, 32'h0000000A);
      sampleCycle();
      checkOutput("t1_m1_ready", {31'b0, m1_mem_ready}, 32'd0);
      nextCycle();
      slaveRespond(1'b0, 32'h0);
      applyStimulus(0, 1'b0, 32'h0, 4'h0, 32'h0);
      sampleCycle();
      checkOutput("t1_idle_after", {30'b0, grant}, 32'd0);

      // Contention after reset: m0, then m1 after one idle cycle, then m0
      doReset();
      applyStimulus(0, 1'b1, 32'h00001000, 4'h0, 32'h0);
      applyStimulus(1, 1'b1, 32'h00002000, 4'h0, 32'h0);
      sampleCycle();
      nextCycle();
      expectResponse(0, 32'h00000011, 1'b0);
      slaveRespond(1'b1, 32'h00000011);
      sampleCycle();
      checkOutput("t2_first_grant", {30'b0, grant}, 32'd1);
      checkOutput("t2_first_addr", s_mem_addr, 32'h00001000);
      nextCycle();
      slaveRespond(1'b0, 32'h0);
      applyStimulus(0, 1'b0, 32'h0, 4'h0, 32'h0);
      sampleCycle();
      checkOutput("t2_idle_gap", {30'b0, grant}, 32'd0);
      nextCycle();
      expectResponse(1, 32'h00000022, 1'b0);
      slaveRespond(1'b1, 32'h00000022);
      sampleCycle();
      checkOutput("t2_second_grant", {30'b0, grant}, 32'd2);
      checkOutput("t2_second_addr", s_mem_addr, 32'h00002000);
      nextCycle();
      slaveRespond(1'b0, 32'h0);
      applyStimulus(0, 1'b1, 32'h00003000, 4'h0, 32'h0);
      applyStimulus(1, 1'b1, 32'h00004000, 4'h0, 32'h0);
      sampleCycle();
      nextCycle();
      expectResponse(0, 32'h00000033, 1'b0);
      slaveRespond(1'b1, 32'h00000033);
      sampleCycle();
      checkOutput("t2_third_grant", {30'b0, grant}, 32'd1);
      nextCycle();
      slaveRespond(1'b0, 32'h0);
      applyStimulus(0, 1'b0, 32'h0, 4'h0, 32'h0);
      applyStimulus(1, 1'b0, 32'h0, 4'h0, 32'h0);
      sampleCycle();

      // m1 write while m0 idle
      nextCycle();
      applyStimulus(1, 1'b1, 32'hFFFF0040, 4'b0001, 32'h00000048);
      sampleCycle();
      nextCycle();
      expectResponse(1, 32'hCAFE0001, 1'b0);
      slaveRespond(1'b1, 32'hCAFE0001);
      sampleCycle();
      checkOutput("t3_s_valid", {31'b0, s_mem_valid}, 32'd1);
      checkOutput("t3_s_addr", s_mem_addr, 32'hFFFF0040);
      checkOutput("t3_s_wdata", s_mem_wdata, 32'h00000048);
      checkOutput("t3_s_wstrb", {28'b0, s_mem_wstrb}, 32'd1);
      checkOutput("t3_m0_ready", {31'b0, m0_mem_ready}, 32'd0);
      checkOutput("t3_m0_rdata", m0_mem_rdata, 32'd0);
      nextCycle();
      slaveRespond(1'b0, 32'h0);
      applyStimulus(1, 1'b0, 32'h0, 4'h0, 32'h0);
      sampleCycle();

      // Watchdog fires in the 8th granted cycle
      nextCycle();
      applyStimulus(0, 1'b1, 32'hFFFF0080, 4'h0, 32'h0);
      sampleCycle();
      for (int k = 1; k < TB_TIMEOUT; k++) begin
         nextCycle();
         sampleCycle();
         checkOutput("t4_wait_ready", {31'b0, m0_mem_ready}, 32'd0);
         checkOutput("t4_wait_err", {31'b0, timeout_err}, 32'd0);
      end
      nextCycle();
      expectResponse(0, 32'hDEADBEEF, 1'b1);
      sampleCycle();
      checkOutput("t4_expire_err", {31'b0, timeout_err}, 32'd1);
      checkOutput("t4_expire_s_valid", {31'b0, s_mem_valid}, 32'd0);
      checkOutput("t4_expire_rdata", m0_mem_rdata, 32'hDEADBEEF);
      nextCycle();
      applyStimulus(0, 1'b0, 32'h0, 4'h0, 32'h0);
      sampleCycle();
      checkOutput("t4_err_pulse_end", {31'b0, timeout_err}, 32'd0);
      checkOutput("t4_idle_after", {30'b0, grant}, 32'd0);

      // Slave ready in the expiry cycle wins
      nextCycle();
      applyStimulus(0, 1'b1, 32'hFFFF0084, 4'h0, 32'h0);
      sampleCycle();
      for (int k = 1; k < TB_TIMEOUT; k++) begin
         nextCycle();
         sampleCycle();
      end
      nextCycle();
      expectResponse(0, 32'h00000055, 1'b0);
      slaveRespond(1'b1, 32'h00000055);
      sampleCycle();
      checkOutput("t4_race_err", {31'b0, timeout_err}, 32'd0);
      checkOutput("t4_race_rdata", m0_mem_rdata, 32'h00000055);
      checkOutput("t4_race_s_valid", {31'b0, s_mem_valid}, 32'd1);
      nextCycle();
      slaveRespond(1'b0, 32'h0);
      applyStimulus(0, 1'b0, 32'h0, 4'h0, 32'h0);
      sampleCycle();

      // Asynchronous reset in the middle of a granted transfer
      nextCycle();
      applyStimulus(0, 1'b1, 32'hFFFF0100, 4'hF, 32'h00000077);
      nextCycle();
      #2;
      checkOutput("t5_grant_before", {30'b0, grant}, 32'd1);
      resetn = 1'b0;
      #1;
      checkOutput("t5_async_grant", {30'b0, grant}, 32'd0);
      checkOutput("t5_async_s_valid", {31'b0, s_mem_valid}, 32'd0);
      checkOutput("t5_async_s_addr", s_mem_addr, 32'd0);
      checkOutput("t5_async_s_wdata", s_mem_wdata, 32'd0);
      checkOutput("t5_async_s_wstrb", {28'b0, s_mem_wstrb}, 32'd0);
      checkOutput("t5_async_m0_rdata", m0_mem_rdata, 32'd0);
      applyStimulus(1, 1'b1, 32'hFFFF0104, 4'h0, 32'h0);
      nextCycle();
      resetn = 1'b1;
      sampleCycle();
      checkOutput("t5_idle_after_release", {30'b0, grant}, 32'd0);
      nextCycle();
      expectResponse(0, 32'h00000066, 1'b0);
      slaveRespond(1'b1, 32'h00000066);
      sampleCycle();
      checkOutput("t5_first_contention", {30'b0, grant}, 32'd1);
      nextCycle();
      slaveRespond(1'b0, 32'h0);
      applyStimulus(0, 1'b0, 32'h0, 4'h0, 32'h0);
      applyStimulus(1, 1'b0, 32'h0, 4'h0, 32'h0);
      sampleCycle();

      // m0 abandons its request, pending m1 is served next
      nextCycle();
      applyStimulus(0, 1'b1, 32'hFFFF0200, 4'h0, 32'h0);
      sampleCycle();
      nextCycle();
      sampleCycle();
      checkOutput("t6_grant0", {30'b0, grant}, 32'd1);
      nextCycle();
      applyStimulus(0, 1'b0, 32'h0, 4'h0, 32'h0);
      applyStimulus(1, 1'b1, 32'hFFFF0204, 4'h0, 32'h0);
      sampleCycle();
      checkOutput("t6_drop_s_valid", {31'b0, s_mem_valid}, 32'd0);
      checkOutput("t6_drop_m0_ready", {31'b0, m0_mem_ready}, 32'd0);
      nextCycle();
      sampleCycle();
      checkOutput("t6_idle", {30'b0, grant}, 32'd0);
      checkOutput("t6_idle_m0_ready", {31'b0, m0_mem_ready}, 32'd0);
      nextCycle();
      expectResponse(1, 32'h00000099, 1'b0);
      slaveRespond(1'b1, 32'h00000099);
      sampleCycle();
      checkOutput("t6_grant1", {30'b0, grant}, 32'd2);
      nextCycle();
      slaveRespond(1'b0, 32'h0);
      applyStimulus(1, 1'b0, 32'h0, 4'h0, 32'h0);
      sampleCycle();

      nextCycle();
      sampleCycle();
      checkOutput("sb_drain", sbQueue.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
